// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the 1-to-4 stream demultiplexer
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    typedef enum logic {IDLE, LOCKED} state_t;
    typedef logic [SEL_W-1:0] ch_t;
endpackage

// File: rtl/stream_slot.sv
// stream_slot: one-entry valid/ready holding register carrying data and last
module stream_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic              free
);
    assign free = ~valid | ready;
    // load wins over drain so a full slot can drain and refill in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux1x4_stream.sv
// demux1x4_stream: packet-aware registered 1-to-4 stream demultiplexer
module demux1x4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_last,
    output logic [NUM_CH*CNT_W-1:0]  pkt_cnt,
    output logic                     busy
);
    state_t state, state_nx;
    ch_t lock_ch, active_ch;
    logic [NUM_CH-1:0] free, load;
    logic accept;
    logic [CNT_W-1:0] cnt [NUM_CH];

    assign active_ch = (state == IDLE) ? in_sel : lock_ch;
    assign in_ready  = ~rst & free[active_ch];
    assign accept    = in_valid & in_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign load[g] = accept && (active_ch == ch_t'(g));
        assign pkt_cnt[g*CNT_W +: CNT_W] = cnt[g];
        stream_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .load_data (in_data),
            .load_last (in_last),
            .ready     (out_ready[g]),
            .valid     (out_valid[g]),
            .data      (out_data[g*DATA_W +: DATA_W]),
            .last      (out_last[g]),
            .free      (free[g])
        );
    end

    // state register; the channel is captured on the first beat of a packet
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            state <= state_nx;
            if (accept && state == IDLE) lock_ch <= in_sel;
        end
    end

    // every accepted beat decides the next state purely from its last flag
    always_comb begin
        state_nx = accept ? (in_last ? IDLE : LOCKED) : state;
    end

    // busy flags an open packet
    always_comb begin
        busy = (state == LOCKED);
    end

    // completed-packet counters advance at the accept of a last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if (accept && in_last) begin
            cnt[active_ch] <= cnt[active_ch] + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux1x4_stream.sv
// tb_demux1x4_stream: randomized self-checking bench with a per-channel reference model
module tb_demux1x4_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_last = 1'b0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] out_data;
    logic [3:0]  out_last;
    logic [31:0] pkt_cnt;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    bit         m_valid [4];
    logic [7:0] m_data  [4];
    bit         m_last  [4];
    logic [7:0] m_cnt   [4];
    bit         m_open = 1'b0;
    int         m_ch = 0;

    demux1x4_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .pkt_cnt   (pkt_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: drive, check in_ready, advance the model, check registered outputs
    task automatic cycle(input bit r, input bit v, input logic [1:0] sel,
                         input logic [7:0] d, input bit l, input logic [3:0] ordy);
        int ch;
        bit rdy;
        logic [3:0]  ev, el;
        logic [31:0] ed, ec;
        rst = r; in_valid = v; in_sel = sel; in_data = d; in_last = l; out_ready = ordy;
        #1;
        ch  = m_open ? m_ch : int'(sel);
        rdy = !r && (!m_valid[ch] || ordy[ch]);
        check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                m_valid[k] = 0; m_data[k] = 0; m_last[k] = 0; m_cnt[k] = 0;
            end
            m_open = 0;
        end else begin
            for (int k = 0; k < 4; k++) if (m_valid[k] && ordy[k]) m_valid[k] = 0;
            if (v && rdy) begin
                m_valid[ch] = 1; m_data[ch] = d; m_last[ch] = l;
                if (l) m_cnt[ch] = m_cnt[ch] + 8'd1;
                m_open = !l;
                m_ch = ch;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            ev[k] = m_valid[k]; el[k] = m_last[k];
            ed[k*8 +: 8] = m_data[k]; ec[k*8 +: 8] = m_cnt[k];
        end
        check("out_valid", {28'b0, out_valid}, {28'b0, ev});
        check("out_data", out_data, ed);
        check("out_last", {28'b0, out_last}, {28'b0, el});
        check("pkt_cnt", pkt_cnt, ec);
        check("busy", {31'b0, busy}, {31'b0, m_open});
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 0; m_data[k] = 0; m_last[k] = 0; m_cnt[k] = 0;
        end
        // reset with in_valid asserted, then release
        cycle(1, 1, 2'd1, 8'h55, 0, 4'hF);
        cycle(1, 1, 2'd1, 8'h55, 0, 4'hF);
        cycle(0, 0, 2'd0, 8'h00, 0, 4'hF);
        // single-beat routing to each channel
        for (int k = 0; k < 4; k++) cycle(0, 1, 2'(k), 8'hA0 + 8'(k), 1, 4'hF);
        cycle(0, 0, 2'd0, 8'h00, 0, 4'hF);
        // lock: select changes mid-packet are ignored
        cycle(0, 1, 2'd2, 8'h11, 0, 4'hF);
        cycle(0, 1, 2'd1, 8'h22, 0, 4'hF);
        cycle(0, 1, 2'd1, 8'h33, 1, 4'hF);
        cycle(0, 0, 2'd0, 8'h00, 0, 4'hF);
        // backpressure on channel 1 does not block channel 3
        cycle(0, 1, 2'd1, 8'h41, 1, 4'hD);
        cycle(0, 1, 2'd1, 8'h42, 1, 4'hD);
        cycle(0, 1, 2'd1, 8'h42, 1, 4'hD);
        cycle(0, 1, 2'd3, 8'h43, 1, 4'hD);
        cycle(0, 1, 2'd1, 8'h42, 1, 4'hF);
        cycle(0, 0, 2'd0, 8'h00, 0, 4'hF);
        // full throughput to channel 0
        for (int i = 0; i < 8; i++) cycle(0, 1, 2'd0, 8'(i + 1), i == 7, 4'hF);
        cycle(0, 0, 2'd0, 8'h00, 0, 4'hF);
        // reset in the middle of a packet on channel 3
        cycle(0, 1, 2'd3, 8'h77, 0, 4'h0);
        cycle(1, 0, 2'd3, 8'h00, 0, 4'h0);
        cycle(0, 1, 2'd0, 8'h88, 0, 4'hF);
        cycle(0, 1, 2'd3, 8'h89, 1, 4'hF);
        // counter wrap on channel 0
        for (int i = 0; i < 256; i++) cycle(0, 1, 2'd0, 8'(i), 1, 4'hF);
        check("wrap", {24'b0, pkt_cnt[7:0]}, 32'd1);
        // randomized traffic
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 2'($urandom),
                  8'($urandom), $urandom_range(0, 2) == 0, 4'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/demux1x4_stream.md
Name: demux1x4_stream

Overview:
- Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4:1 selection mux.
- One input stream with valid/ready and a 2-bit select is steered to one of four output channels.
- Each output channel has a one-entry holding register.
- Packet-aware: once a packet starts, its channel is locked until the last beat, so packets never interleave across channels.
- Sits in front of four independent consumers that share one producer.

Parameters:
- DATA_W, 8, width of one data beat.
- CNT_W, 8, width of each per-channel completed-packet counter (wraps).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- in_data  input  DATA_W  input beat payload.
- in_sel  input  2  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  marks final beat of packet.
- out_valid  output  4  per-channel beat valid; bit k = channel k.
- out_ready  input  4  per-channel consumer ready.
- out_data  output  4*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- out_last  output  4  per-channel last flag.
- pkt_cnt  output  4*CNT_W  channel k completed-packet count at [k*CNT_W +: CNT_W].
- busy  output  1  high while in LOCKED state.

Behaviour:
- Reset is synchronous and active-high, on clk; it is the only reset.
  - At rst=1, every output goes to zero on the next edge: out_valid=0, out_data=0, out_last=0, pkt_cnt=0, busy=0, state=IDLE.
  - in_ready is combinational and therefore also 0 while the slots are empty and rst is high.
- Channel select:
  - active_ch = in_sel when state=IDLE.
  - active_ch = the locked channel register when state=LOCKED.
- Slot k is free when out_valid[k]=0 or out_ready[k]=1 (drain and refill in the same cycle).
- in_ready = ~rst & (slot[active_ch] free). This is combinational from state, out_valid, out_ready and in_sel; there is no dependency on in_valid.
- Accept (in_valid & in_ready):
  - Next edge: slot[active_ch] loads in_data and in_last, and out_valid[active_ch]=1.
  - Latency is one cycle from accept to out_valid.
  - With continuous out_ready, throughput is one beat per clock.
- Drain: out_valid[k] & out_ready[k] with no refill clears out_valid[k] next edge.
  - out_data and out_last hold their last value; they are don't-care when not valid.
- Output stability: out_valid[k], out_data[k] and out_last[k] stay constant while out_valid[k]=1 and out_ready[k]=0.
- State machine:
  - IDLE: accept with in_last=0 -> LOCKED, lock_ch=in_sel. Accept with in_last=1 (single-beat packet) -> stay IDLE.
  - LOCKED: in_sel is ignored. Accept with in_last=1 -> IDLE. Otherwise stay.
  - busy = (state==LOCKED).
- pkt_cnt[k] increments by 1 (mod 2^CNT_W) on each accepted beat with in_last=1 destined for channel k. It counts at the accept, not at the drain.
- Channels never block each other: a stalled channel k only stalls the input while active_ch==k.
- Boundary cases:
  - in_sel changes mid-packet: ignored; beats still go to lock_ch.
  - in_sel changes in IDLE while in_valid is high and the slot is full: the new value is used in the cycle it is presented.
  - Counter at 2^CNT_W-1 with a last-accept: wraps to 0.
  - Reset mid-packet: all slots are dropped and state returns to IDLE. The next beat after reset is treated as a first beat.
  - Only one slot can load per cycle. Any number of slots can drain per cycle.

Decomposition:
- Shared package demux_pkg:
  - State enum (IDLE, LOCKED).
  - NUM_CH=4 and SEL_W=2 constants.
  - Channel index type.
- One natural sub-module, stream_slot: a one-entry valid/ready holding register carrying data and last, with load, drain and free outputs, instantiated four times.
- The top level holds the FSM, the select logic and the counters.

Test Plan:
- Reset check: drive rst=1 for 2 cycles with in_valid=1. Expect out_valid=0000, pkt_cnt all 0, busy=0, in_ready=0. Release rst: in_ready=1.
- Single-beat routing: send in_sel=0..3, in_last=1, data 0xA0..0xA3, all out_ready=1. Expect each beat to appear one cycle later only on its channel, with out_last=1. pkt_cnt becomes 1 on every channel.
- Lock behaviour: send a 3-beat packet, in_sel=2 on beat 0, then in_sel=1 on beats 1–2, data 0x11,0x22,0x33. Expect all three beats on channel 2, busy=1 for beats 1–2, then busy=0. pkt_cnt[2] +1, pkt_cnt[1] unchanged.
- Backpressure isolation: hold out_ready[1]=0 and send two beats to channel 1. Expect the first to hold stable on channel 1 and in_ready=0 for the second. Then a packet with in_sel=3 passes with 1-cycle latency. Raising out_ready[1] releases it.
- Full throughput: out_ready=1111, stream 8 back-to-back beats to channel 0. Expect in_ready=1 every cycle and 8 consecutive out_valid[0] cycles with data in order.
- Mid-packet reset and wrap: start a packet on channel 3, assert rst for 1 cycle. Expect out_valid=0 and busy=0. Next beat with in_sel=0 goes to channel 0. Preload via 255 single-beat packets to channel 0, then send one more: pkt_cnt[0] wraps to 0.
